// File: rtl/digit_bank_pkg.sv
// Shared constants and types for the digit bank and its downstream 6:1 digit selector.
package digit_bank_pkg;

    localparam int NUM_SLOTS = 6;
    localparam int SEL_W     = 3;
    localparam int DIGIT_W   = 4;
    localparam int CNT_W     = 3;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    localparam digit_t BCD_MAX = digit_t'(9);

    // Storage operation selected for the current cycle, already priority-resolved.
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_CLR   = 2'd1,
        OP_WRITE = 2'd2,
        OP_SHIFT = 2'd3
    } op_e;

    function automatic logic is_bcd(input digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/digit_bank_scan.sv
// Scan-select sequencer: a prescaler that steps sel through 0..NUM_SLOTS-1 once per SCAN_DIV enabled clocks.
module scan_counter
    import digit_bank_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output sel_t sel
);

    localparam int   PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(SCAN_DIV - 1);
    localparam sel_t SEL_LAST = sel_t'(NUM_SLOTS - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    sel_t             sel_q, sel_d;

    always_comb begin
        pre_d = pre_q;
        sel_d = sel_q;
        if (en) begin
            if (pre_q == PRE_TERM) begin
                pre_d = '0;
                // >= rather than == so an illegal code can never persist.
                sel_d = (sel_q >= SEL_LAST) ? '0 : sel_q + sel_t'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            sel_q <= '0;
        end else begin
            pre_q <= pre_d;
            sel_q <= sel_d;
        end
    end

    assign sel = sel_q;

endmodule

// File: rtl/digit_bank.sv
// Six-slot BCD digit store with keypad shift entry, direct writes and a scan-select sequencer.
module digit_bank #(
    parameter int SCAN_DIV  = 50000,
    parameter int NUM_SLOTS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       shift_en,
    input  logic [3:0] shift_data,
    input  logic       scan_en,
    output logic [3:0] slot1,
    output logic [3:0] slot2,
    output logic [3:0] slot3,
    output logic [3:0] slot4,
    output logic [3:0] slot5,
    output logic [3:0] slot6,
    output logic [2:0] scan_sel,
    output logic [2:0] digit_cnt,
    output logic       full,
    output logic       err
);
    import digit_bank_pkg::*;

    localparam cnt_t CNT_FULL  = cnt_t'(NUM_SLOTS);
    localparam sel_t ADDR_LIMIT = sel_t'(NUM_SLOTS);

    digit_t slot_q [NUM_SLOTS];
    digit_t slot_d [NUM_SLOTS];
    cnt_t   cnt_q, cnt_d;
    logic   err_q, err_d;
    op_e    op;
    logic   wr_ok;
    logic   sh_ok;

    // clr > wr_en > shift_en; a losing strobe is simply dropped.
    always_comb begin
        op = OP_NONE;
        if (clr) begin
            op = OP_CLR;
        end else if (wr_en) begin
            op = OP_WRITE;
        end else if (shift_en) begin
            op = OP_SHIFT;
        end
    end

    assign wr_ok = (wr_addr < ADDR_LIMIT) && is_bcd(wr_data);
    assign sh_ok = (cnt_q < CNT_FULL) && is_bcd(shift_data);

    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;
        err_d  = 1'b0;
        unique case (op)
            OP_CLR: begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    slot_d[i] = '0;
                end
                cnt_d = '0;
            end
            OP_WRITE: begin
                if (wr_ok) begin
                    slot_d[wr_addr] = wr_data;
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_SHIFT: begin
                if (sh_ok) begin
                    for (int i = NUM_SLOTS - 1; i > 0; i--) begin
                        slot_d[i] = slot_q[i-1];
                    end
                    slot_d[0] = shift_data;
                    cnt_d     = cnt_q + cnt_t'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    scan_counter #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk(clk),
        .rst(rst),
        .en (scan_en),
        .sel(scan_sel)
    );

    assign slot1     = slot_q[0];
    assign slot2     = slot_q[1];
    assign slot3     = slot_q[2];
    assign slot4     = slot_q[3];
    assign slot5     = slot_q[4];
    assign slot6     = slot_q[5];
    assign digit_cnt = cnt_q;
    assign full      = (cnt_q == CNT_FULL);
    assign err       = err_q;

endmodule

// File: tb/tb_digit_bank.sv
// Bench for digit_bank: directed vector table, scan/reset sequences, then random traffic against a queue model.
module tb_digit_bank;

    logic       clk = 1'b0;
    logic       rst, clr, wr_en, shift_en, scan_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data, shift_data;
    logic [3:0] slot1, slot2, slot3, slot4, slot5, slot6;
    logic [2:0] scan_sel, digit_cnt;
    logic       full, err;

    always #5 clk = ~clk;

    digit_bank #(.SCAN_DIV(3), .NUM_SLOTS(6)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .shift_en(shift_en), .shift_data(shift_data),
        .scan_en(scan_en), .slot1(slot1), .slot2(slot2), .slot3(slot3),
        .slot4(slot4), .slot5(slot5), .slot6(slot6), .scan_sel(scan_sel),
        .digit_cnt(digit_cnt), .full(full), .err(err)
    );

    typedef struct {
        logic        rst, clr, we;
        logic [2:0]  addr;
        logic [3:0]  wd;
        logic        se;
        logic [3:0]  sd;
        logic [23:0] slots;
        logic [2:0]  cnt;
        logic        full, err;
    } vec_t;

    vec_t tbl[20];
    int   exp_sel[20] = '{0,0,1,1,1,2,2,2,3,3,3,4,4,4,5,5,5,0,0,0};
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: the six slots as a queue, entered digits pushed at the front.
    int   m_slot[$];
    int   m_cnt;
    int   m_en;
    logic m_err;

    function automatic vec_t mk(logic r, logic c, logic we, logic [2:0] a, logic [3:0] wd,
                                logic se, logic [3:0] sd, logic [23:0] s, logic [2:0] n,
                                logic f, logic e);
        vec_t v;
        v.rst = r; v.clr = c; v.we = we; v.addr = a; v.wd = wd; v.se = se; v.sd = sd;
        v.slots = s; v.cnt = n; v.full = f; v.err = e;
        return v;
    endfunction

    function automatic logic [23:0] dut_slots();
        return {slot6, slot5, slot4, slot3, slot2, slot1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = '{0, 0, 0, 0, 0, 0};
        m_cnt  = 0;
        m_en   = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            m_err = 1'b0;
            if (clr) begin
                m_slot = '{0, 0, 0, 0, 0, 0};
                m_cnt  = 0;
            end else if (wr_en) begin
                if (wr_addr < 6 && wr_data <= 9) m_slot[wr_addr] = int'(wr_data);
                else m_err = 1'b1;
            end else if (shift_en) begin
                if (shift_data <= 9 && m_cnt < 6) begin
                    m_slot.push_front(int'(shift_data));
                    void'(m_slot.pop_back());
                    m_cnt++;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (scan_en) m_en++;
        end
    endtask

    task automatic check_model(input string tag);
        logic [23:0] es;
        es = '0;
        for (int i = 0; i < 6; i++) es[i*4 +: 4] = 4'(m_slot[i]);
        check({tag, "_slots"}, 32'(dut_slots()), 32'(es));
        check({tag, "_cnt"},   32'(digit_cnt), 32'(m_cnt));
        check({tag, "_full"},  32'(full), 32'(m_cnt == 6));
        check({tag, "_err"},   32'(err), 32'(m_err));
        check({tag, "_sel"},   32'(scan_sel), 32'((m_en / 3) % 6));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; clr = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
        shift_en = 0; shift_data = '0; scan_en = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        model_reset();

        tbl[0]  = mk(1,0,0,0,0, 0,0,  24'h000000, 0, 0, 0);
        tbl[1]  = mk(0,0,0,0,0, 1,1,  24'h000001, 1, 0, 0);
        tbl[2]  = mk(0,0,0,0,0, 1,2,  24'h000012, 2, 0, 0);
        tbl[3]  = mk(0,0,0,0,0, 1,3,  24'h000123, 3, 0, 0);
        tbl[4]  = mk(0,0,0,0,0, 1,4,  24'h001234, 4, 0, 0);
        tbl[5]  = mk(0,0,0,0,0, 1,5,  24'h012345, 5, 0, 0);
        tbl[6]  = mk(0,0,0,0,0, 1,6,  24'h123456, 6, 1, 0);
        tbl[7]  = mk(0,0,0,0,0, 1,7,  24'h123456, 6, 1, 1);
        tbl[8]  = mk(0,0,0,0,0, 0,0,  24'h123456, 6, 1, 0);
        tbl[9]  = mk(0,0,1,4,8, 0,0,  24'h183456, 6, 1, 0);
        tbl[10] = mk(0,0,1,6,1, 0,0,  24'h183456, 6, 1, 1);
        tbl[11] = mk(0,0,1,2,12,0,0,  24'h183456, 6, 1, 1);
        tbl[12] = mk(0,1,1,0,5, 1,3,  24'h000000, 0, 0, 0);
        tbl[13] = mk(0,0,0,0,0, 1,10, 24'h000000, 0, 0, 1);
        tbl[14] = mk(0,0,1,0,9, 0,0,  24'h000009, 0, 0, 0);
        tbl[15] = mk(0,0,0,0,0, 1,2,  24'h000092, 1, 0, 0);
        tbl[16] = mk(0,0,1,7,3, 1,4,  24'h000092, 1, 0, 1);
        tbl[17] = mk(0,0,1,1,7, 1,5,  24'h000072, 1, 0, 0);
        tbl[18] = mk(0,1,0,0,0, 1,4,  24'h000000, 0, 0, 0);
        tbl[19] = mk(0,0,0,0,0, 1,5,  24'h000005, 1, 0, 0);
        tbl[18].rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            idle();
            rst = tbl[i].rst; clr = tbl[i].clr; wr_en = tbl[i].we;
            wr_addr = tbl[i].addr; wr_data = tbl[i].wd;
            shift_en = tbl[i].se; shift_data = tbl[i].sd;
            cycle();
            check($sformatf("v%0d_slots", i), 32'(dut_slots()), 32'(tbl[i].slots));
            check($sformatf("v%0d_cnt", i),   32'(digit_cnt), 32'(tbl[i].cnt));
            check($sformatf("v%0d_full", i),  32'(full), 32'(tbl[i].full));
            check($sformatf("v%0d_err", i),   32'(err), 32'(tbl[i].err));
            check($sformatf("v%0d_sel", i),   32'(scan_sel), 32'd0);
        end

        // Scan sequencing with SCAN_DIV=3, then a five-cycle freeze.
        idle(); rst = 1; cycle();
        check("scan_rst_sel", 32'(scan_sel), 32'd0);
        rst = 0; scan_en = 1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            check($sformatf("scan_k%0d", k + 1), 32'(scan_sel), 32'(exp_sel[k]));
        end
        scan_en = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check($sformatf("freeze_%0d", k), 32'(scan_sel), 32'd0);
        end
        // Prescaler held at 2, so the first enabled edge advances sel; shifts must not disturb it.
        scan_en = 1; shift_en = 1; shift_data = 3;
        cycle();
        check("resume_k21_sel", 32'(scan_sel), 32'd1);
        check("resume_k21_cnt", 32'(digit_cnt), 32'd1);
        shift_data = 4;
        cycle();
        check("resume_k22_sel", 32'(scan_sel), 32'd1);
        shift_en = 0;
        cycle();
        check("resume_k23_sel", 32'(scan_sel), 32'd1);
        cycle();
        check("resume_k24_sel", 32'(scan_sel), 32'd2);
        cycle();
        check("resume_k25_sel", 32'(scan_sel), 32'd2);

        // Reset in the middle of a prescaler count and a shift sequence.
        rst = 1; shift_en = 1; shift_data = 5; clr = 1;
        cycle();
        check("midrst_sel",   32'(scan_sel), 32'd0);
        check("midrst_cnt",   32'(digit_cnt), 32'd0);
        check("midrst_slots", 32'(dut_slots()), 32'd0);
        check("midrst_full",  32'(full), 32'd0);
        check("midrst_err",   32'(err), 32'd0);
        rst = 0; clr = 0; shift_data = 7;
        cycle();
        check("post_cnt",   32'(digit_cnt), 32'd1);
        check("post_slots", 32'(dut_slots()), 32'h7);
        check("post_sel1",  32'(scan_sel), 32'd0);
        shift_en = 0;
        cycle();
        check("post_sel2", 32'(scan_sel), 32'd0);
        cycle();
        check("post_sel3", 32'(scan_sel), 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 59) == 0);
            clr        = ($urandom_range(0, 24) == 0);
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = 4'($urandom_range(0, 15));
            shift_en   = ($urandom_range(0, 1) == 0);
            shift_data = 4'($urandom_range(0, 12));
            scan_en    = ($urandom_range(0, 3) != 0);
            cycle();
            check_model($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/digit_bank.md
DIGIT_BANK -- requirements
Module: digit_bank

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50000, meaning clocks per scan-select step (minimum 1).
REQ-002 SHALL provide parameter NUM_SLOTS, default 6, meaning number of 4-bit digit slots; fixed at 6 for this release.
REQ-003 SHALL provide port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL provide port rst, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL provide port clr, input, 1, meaning clear all slots and the digit count.
REQ-006 SHALL provide port wr_en, input, 1, meaning direct-write strobe.
REQ-007 SHALL provide port wr_addr, input, 3, meaning target slot, 0..5 maps to slot1..slot6.
REQ-008 SHALL provide port wr_data, input, 4, meaning BCD digit for a direct write.
REQ-009 SHALL provide port shift_en, input, 1, meaning keypad-entry strobe.
REQ-010 SHALL provide port shift_data, input, 4, meaning BCD digit shifted in at slot1.
REQ-011 SHALL provide port scan_en, input, 1, meaning enable the scan-select sequencer.
REQ-012 SHALL provide ports slot1..slot6, output, 4 each, meaning registered digit values; slot1 is least significant.
REQ-013 SHALL provide port scan_sel, output, 3, meaning current select code 0..5 for the downstream 6:1 selector.
REQ-014 SHALL provide port digit_cnt, output, 3, meaning number of digits entered via shift, 0..6.
REQ-015 SHALL provide port full, output, 1, meaning digit_cnt == 6.
REQ-016 SHALL provide port err, output, 1, meaning one-cycle pulse on a rejected request.

Function
REQ-017 SHALL apply at most one storage operation per cycle, priority clr > wr_en > shift_en; lower-priority strobes in the same cycle are dropped without err.
REQ-018 clr SHALL zero slot1..slot6 and digit_cnt on the next edge.
REQ-019 wr_en with wr_addr 0..5 and wr_data <= 9 SHALL load the addressed slot next cycle; digit_cnt unchanged.
REQ-020 wr_en with wr_addr 6/7 or wr_data > 9 SHALL leave all slots unchanged and pulse err for one cycle.
REQ-021 shift_en with shift_data <= 9 and digit_cnt < 6 SHALL move slotN into slotN+1 for N=1..5, load shift_data into slot1, and increment digit_cnt, all on one edge.
REQ-022 shift_en when full, or with shift_data > 9, SHALL leave slots and digit_cnt unchanged and pulse err.
REQ-023 Slot outputs SHALL reflect an accepted operation exactly one cycle after the strobe; the outputs are registered with no combinational path from inputs.
REQ-024 The prescaler SHALL count 0..SCAN_DIV-1 while scan_en=1; at terminal count it SHALL wrap to 0 and advance scan_sel 0,1,2,3,4,5,0.
REQ-025 scan_sel SHALL never take values 6 or 7.
REQ-026 When scan_en=0, the prescaler and scan_sel SHALL hold their values; on re-enable, counting SHALL resume from the held values.
REQ-027 Storage operations SHALL NOT affect the prescaler or scan_sel.

Reset
REQ-028 When rst=1 at a clock edge, all slots, digit_cnt, prescaler, scan_sel, full and err SHALL be 0.
REQ-029 rst SHALL override every input in the same cycle, including clr, wr_en, shift_en and mid-count scanning.
REQ-030 rst SHALL have no asynchronous effect.

Structure
REQ-031 A shared package SHALL hold NUM_SLOTS=6, SEL_W=3, DIGIT_W=4 and BCD_MAX=9 for use by this block and the 6:1 selector.
REQ-032 The prescaler and scan_sel sequencer SHALL be a sub-module named scan_counter with ports clk, rst, en, sel.
REQ-033 The slot registers SHALL reside in digit_bank.

Verification
REQ-034 Reset followed by shift of 1,2,3 -> slot3..slot1 = 1,2,3, digit_cnt=3, full=0, err never asserted.
REQ-035 Shift of 7 digits 1..7 -> after six shifts, slot6..slot1 = 1..6 and full=1; the seventh shift pulses err for one cycle and leaves the slots unchanged.
REQ-036 wr_en with addr=4, data=8 -> slot5=8 next cycle; addr=6 or data=12 -> err pulse, no change.
REQ-037 clr, wr_en and shift_en asserted in the same cycle -> all slots 0 and digit_cnt=0; rst together with clr -> all outputs 0.
REQ-038 SCAN_DIV=3 with scan_en=1 -> scan_sel advances every 3 clocks through 0..5 and wraps to 0; dropping scan_en for 5 cycles freezes scan_sel and the prescaler.
REQ-039 rst asserted mid-shift-sequence and mid-scan -> all state returns to 0 on the next edge; subsequent shifts start at digit_cnt=0.
